// File: rtl/toy_cpu_pkg.sv
// toy_cpu_pkg: shared loader/CPU state encoding and code-memory geometry
package toy_cpu_pkg;
    localparam int CMEM_ADDR_W = 6;
    localparam int CMEM_DATA_W = 16;
    typedef enum logic [1:0] {IDLE = 2'b00, LOAD = 2'b01, RUN = 2'b10, HALT = 2'b11} state_t;
endpackage

// File: rtl/load_checksum.sv
// load_checksum: 8-bit running sum of both bytes of each added word
module load_checksum
    import toy_cpu_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clr,
    input  logic                   add,
    input  logic [CMEM_DATA_W-1:0] word,
    output logic [7:0]             sum
);
    // clear at load start, accumulate each accepted program word
    always_ff @(posedge clk)
        if (reset || clr) sum <= 8'h00;
        else if (add) sum <= sum + word[7:0] + word[15:8];
endmodule

// File: rtl/program_loader.sv
// program_loader: switch-driven code-memory loader and CPU run/halt control; LOADER_CHECKSUM_EN adds a trailing checksum word
module program_loader
    import toy_cpu_pkg::*;
#(
    parameter int ADDR_W = CMEM_ADDR_W,
    parameter int DATA_W = CMEM_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_req,
    input  logic [ADDR_W-1:0] load_len,
    input  logic              word_valid,
    input  logic [DATA_W-1:0] switches,
    input  logic              run_req,
    input  logic              halt_req,
    output logic              cmem_we,
    output logic [ADDR_W-1:0] cmem_addr,
    output logic [DATA_W-1:0] cmem_wdata,
    output logic              cpu_rst,
    output logic              cpu_en,
    output logic              loaded,
    output logic [1:0]        state,
    output logic              err
);
    state_t            st, ns;
    logic [ADDR_W-1:0] idx, len;
    logic              fin;
    logic              start, accept, load_done;

    assign state  = st;
    assign start  = (ns == LOAD) && (st != LOAD);
    assign accept = (st == LOAD) && !fin && word_valid;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0] sum;
    // the word after the final program word is the checksum; it ends the load
    assign load_done = fin && word_valid;
    load_checksum u_cks (
        .clk  (clk),
        .reset(reset),
        .clr  (start),
        .add  (accept),
        .word (switches),
        .sum  (sum)
    );
`else
    // one settle cycle after the final word keeps its write inside LOAD
    assign load_done = fin;
    assign err = 1'b0;
`endif

    // next-state selection; load_req has priority over run_req
    always_comb begin
        ns = st;
        case (st)
            IDLE:    ns = load_req ? LOAD : (run_req && loaded) ? RUN : IDLE;
            LOAD:    ns = load_done ? IDLE : LOAD;
            RUN:     ns = halt_req ? HALT : RUN;
            default: ns = load_req ? LOAD : run_req ? RUN : HALT;
        endcase
    end

    // state, word index and all registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            st         <= IDLE;
            idx        <= '0;
            len        <= '0;
            fin        <= 1'b0;
            cmem_we    <= 1'b0;
            cmem_addr  <= '0;
            cmem_wdata <= '0;
            cpu_rst    <= 1'b1;
            cpu_en     <= 1'b0;
            loaded     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            err        <= 1'b0;
`endif
        end else begin
            st      <= ns;
            cpu_rst <= (ns == IDLE) || (ns == LOAD);
            cpu_en  <= ns == RUN;
            cmem_we <= accept;
            if (start) begin
                len    <= load_len;
                idx    <= '0;
                fin    <= 1'b0;
                loaded <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
                err    <= 1'b0;
`endif
            end
            if (accept) begin
                cmem_addr  <= idx;
                cmem_wdata <= switches;
                idx        <= idx + 1'b1;
                fin        <= idx == len;
            end
`ifdef LOADER_CHECKSUM_EN
            if (st == LOAD && load_done) begin
                loaded <= switches[7:0] == sum;
                err    <= switches[7:0] != sum;
            end
`else
            if (st == LOAD && load_done) loaded <= 1'b1;
`endif
        end
    end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: table-driven and sequence checks for program_loader
module tb_program_loader;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load_req = 1'b0;
    logic [5:0]  load_len = '0;
    logic        word_valid = 1'b0;
    logic [15:0] switches = '0;
    logic        run_req = 1'b0;
    logic        halt_req = 1'b0;
    logic        cmem_we, cpu_rst, cpu_en, loaded, err;
    logic [5:0]  cmem_addr;
    logic [15:0] cmem_wdata;
    logic [1:0]  state;

`ifdef LOADER_CHECKSUM_EN
    localparam logic CK = 1'b1;
`else
    localparam logic CK = 1'b0;
`endif

    program_loader dut (
        .clk       (clk),
        .reset     (reset),
        .load_req  (load_req),
        .load_len  (load_len),
        .word_valid(word_valid),
        .switches  (switches),
        .run_req   (run_req),
        .halt_req  (halt_req),
        .cmem_we   (cmem_we),
        .cmem_addr (cmem_addr),
        .cmem_wdata(cmem_wdata),
        .cpu_rst   (cpu_rst),
        .cpu_en    (cpu_en),
        .loaded    (loaded),
        .state     (state),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, lreq;
        logic [5:0]  len;
        logic        wv;
        logic [15:0] sw;
        logic        rreq, hreq;
        logic        we;
        logic [5:0]  addr;
        logic [15:0] wd;
        logic [1:0]  st;
        logic        ld, crst, cen;
    } vec_t;

    vec_t v[22];
    int   npass = 0;
    int   ntot = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        ntot++;
        if (got === exp) npass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic drive(input logic r, input logic lq, input logic [5:0] ln, input logic wv,
                         input logic [15:0] sw, input logic rq, input logic hq);
        reset = r; load_req = lq; load_len = ln; word_valid = wv; switches = sw;
        run_req = rq; halt_req = hq;
        @(posedge clk);
        #1;
    endtask

    logic [7:0] ck;

    initial begin
        // rst lreq len wv sw rreq hreq | we addr wd st ld crst cen
        v[0]  = '{1, 0, 0, 0, 16'h0000,     0, 0, 0, 0, 16'h0000, 2'd0, 0, 1, 0};
        v[1]  = '{0, 0, 0, 0, 16'h0000,     0, 0, 0, 0, 16'h0000, 2'd0, 0, 1, 0};
        v[2]  = '{0, 1, 2, 0, 16'h0000,     0, 0, 0, 0, 16'h0000, 2'd1, 0, 1, 0};
        v[3]  = '{0, 0, 0, 1, 16'h1203,     0, 0, 1, 0, 16'h1203, 2'd1, 0, 1, 0};
        v[4]  = '{0, 0, 0, 1, 16'h2401,     0, 0, 1, 1, 16'h2401, 2'd1, 0, 1, 0};
        v[5]  = '{0, 0, 0, 1, 16'h0000,     0, 0, 1, 2, 16'h0000, 2'd1, 0, 1, 0};
        v[6]  = '{0, 0, 0, CK, CK ? 16'h003A : 16'h0000, 0, 0, 0, 2, 16'h0000, 2'd0, 1, 1, 0};
        v[7]  = '{0, 0, 0, 0, 16'h0000,     1, 0, 0, 2, 16'h0000, 2'd2, 1, 0, 1};
        v[8]  = '{0, 0, 0, 0, 16'h0000,     0, 1, 0, 2, 16'h0000, 2'd3, 1, 0, 0};
        v[9]  = '{0, 0, 0, 0, 16'h0000,     1, 0, 0, 2, 16'h0000, 2'd2, 1, 0, 1};
        v[10] = '{0, 1, 5, 1, 16'h7777,     1, 0, 0, 2, 16'h0000, 2'd2, 1, 0, 1};
        v[11] = '{0, 0, 0, 0, 16'h0000,     0, 1, 0, 2, 16'h0000, 2'd3, 1, 0, 0};
        v[12] = '{0, 1, 0, 0, 16'h0000,     1, 0, 0, 2, 16'h0000, 2'd1, 0, 1, 0};
        v[13] = '{0, 0, 0, 1, 16'hABCD,     0, 0, 1, 0, 16'hABCD, 2'd1, 0, 1, 0};
        v[14] = '{0, 0, 0, CK, CK ? 16'h0078 : 16'h0000, 0, 0, 0, 0, 16'hABCD, 2'd0, 1, 1, 0};
        v[15] = '{0, 0, 0, 1, 16'h5555,     0, 0, 0, 0, 16'hABCD, 2'd0, 1, 1, 0};
        v[16] = '{0, 1, 3, 0, 16'h0000,     1, 0, 0, 0, 16'hABCD, 2'd1, 0, 1, 0};
        v[17] = '{0, 0, 0, 1, 16'h1111,     0, 0, 1, 0, 16'h1111, 2'd1, 0, 1, 0};
        v[18] = '{0, 0, 0, 1, 16'h2222,     0, 0, 1, 1, 16'h2222, 2'd1, 0, 1, 0};
        v[19] = '{1, 0, 0, 1, 16'h3333,     0, 0, 0, 0, 16'h0000, 2'd0, 0, 1, 0};
        v[20] = '{0, 0, 0, 1, 16'h3333,     0, 0, 0, 0, 16'h0000, 2'd0, 0, 1, 0};
        v[21] = '{0, 0, 0, 0, 16'h0000,     1, 0, 0, 0, 16'h0000, 2'd0, 0, 1, 0};

        for (int i = 0; i < 22; i++) begin
            drive(v[i].rst, v[i].lreq, v[i].len, v[i].wv, v[i].sw, v[i].rreq, v[i].hreq);
            chk($sformatf("vec%0d we/addr/wd/st/ld/rst/en/err", i),
                {5'b0, cmem_we, cmem_addr, cmem_wdata, state, loaded, cpu_rst, cpu_en, err},
                {5'b0, v[i].we, v[i].addr, v[i].wd, v[i].st, v[i].ld, v[i].crst, v[i].cen, 1'b0});
        end

        // full 64-word load: index must reach 63 without wrapping
        drive(0, 1, 6'd63, 0, 16'h0, 0, 0);
        chk("full_load_enter", {30'b0, state}, 32'd1);
        ck = 8'h00;
        for (int i = 0; i < 64; i++) begin
            drive(0, 0, 6'd0, 1, 16'h0100 + 16'(i), 0, 0);
            ck = ck + 8'h01 + 8'(i);
            chk($sformatf("full_load_w%0d we/addr/wd", i), {9'b0, cmem_we, cmem_addr, cmem_wdata},
                {9'b0, 1'b1, 6'(i), 16'h0100 + 16'(i)});
        end
        drive(0, 0, 6'd0, CK, CK ? {8'h00, ck} : 16'h0, 0, 0);
        chk("full_load_done st/ld/we", {28'b0, state, loaded, cmem_we}, {28'b0, 2'd0, 1'b1, 1'b0});
        drive(0, 0, 6'd0, 0, 16'h0, 0, 0);
        chk("full_load_no_wrap we/addr", {25'b0, cmem_we, cmem_addr}, {25'b0, 1'b0, 6'd63});

`ifdef LOADER_CHECKSUM_EN
        drive(1, 0, 6'd0, 0, 16'h0, 0, 0);
        drive(0, 1, 6'd1, 0, 16'h0, 0, 0);
        drive(0, 0, 6'd0, 1, 16'h0102, 0, 0);
        drive(0, 0, 6'd0, 1, 16'h0304, 0, 0);
        chk("cks_extra_pending st", {30'b0, state}, 32'd1);
        drive(0, 0, 6'd0, 1, 16'h000A, 0, 0);
        chk("cks_good st/ld/err/we", {27'b0, state, loaded, err, cmem_we}, {27'b0, 2'd0, 1'b1, 1'b0, 1'b0});
        drive(0, 1, 6'd1, 0, 16'h0, 0, 0);
        drive(0, 0, 6'd0, 1, 16'h0102, 0, 0);
        drive(0, 0, 6'd0, 1, 16'h0304, 0, 0);
        drive(0, 0, 6'd0, 1, 16'h000B, 0, 0);
        chk("cks_bad st/ld/err/we", {27'b0, state, loaded, err, cmem_we}, {27'b0, 2'd0, 1'b0, 1'b1, 1'b0});
`endif

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
